conv3x3_window_gen: RTL and testbench
=====================================

Name: conv3x3_window_gen

Overview:
- Sits directly downstream of the 12-deep, 128-bit-wide row delay FIFOs in the layer-3 datapath. Two such FIFOs are cascaded, so this block receives three vertically aligned pixel streams.
- Assembles a sliding 3x3 window of feature-map words from those streams and tracks row/column position with counters.
- Emits one valid window per legal convolution position (no padding) to the MAC array.
- Flags frame completion, and flags a broken stream, which the delay FIFOs cannot tolerate because they shift every cycle.

Parameters:
- DATA_W, 128, width of one pixel/channel word (matches the delay FIFO width).
- ROW_W, 12, pixels per row; must equal the depth of each upstream delay FIFO.
- ROW_H, 12, rows per frame.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  current-row pixel valid; once high, must stay high for the whole frame.
- in_data  input  DATA_W  current (bottom) row pixel.
- row1_data  input  DATA_W  output of first delay FIFO (middle row).
- row2_data  input  DATA_W  output of second delay FIFO (top row).
- out_valid  output  1  out_window holds a legal 3x3 window.
- out_window  output  9*DATA_W  packed window; element (r,c) at bits [(r*3+c)*DATA_W +: DATA_W]; r=0 top, c=0 leftmost/oldest.
- out_row  output  $clog2(ROW_H)  output row index of window (0..ROW_H-3).
- out_col  output  $clog2(ROW_W)  output column index of window (0..ROW_W-3).
- frame_done  output  1  one-cycle pulse with the last window of a frame.
- stream_err  output  1  one-cycle pulse when in_valid drops mid-frame.

Behaviour:
- Reset values: all window registers 0, out_valid 0, out_window 0, out_row/out_col 0, frame_done 0, stream_err 0, counters 0, state IDLE. Reset is asynchronous and takes effect mid-frame with no drain.
- Window shift happens on every accepted pixel (in_valid=1 in IDLE or RUN):
  - w[r][0]<=w[r][1], w[r][1]<=w[r][2].
  - w[0][2]<=row2_data, w[1][2]<=row1_data, w[2][2]<=in_data.
- Counters:
  - col increments per accepted pixel and wraps ROW_W-1 -> 0.
  - row increments on col wrap.
- States:
  - IDLE: counters 0. in_valid=1 accepts pixel (0,0) and moves to RUN.
  - RUN: accepts a pixel each cycle.
    - After accepting (ROW_H-1, ROW_W-1): go to IDLE and clear counters.
    - in_valid=0 in RUN: go to IDLE, clear counters, pulse stream_err next cycle. Window registers are not cleared. No out_valid until a new frame fills.
- Output timing, registered with 1-cycle latency:
  - Accepting the pixel at (row,col) with row>=2 and col>=2 sets out_valid=1 next cycle.
  - In that cycle out_row=row-2, out_col=col-2, and out_window holds the window whose bottom-right is that pixel. Otherwise out_valid=0.
- frame_done is high in the same cycle as out_valid for position (ROW_H-3, ROW_W-3).
- Windows per frame: (ROW_H-2)*(ROW_W-2) = 100 at default.
- Column wrap: the first two pixels of each row produce no out_valid, even though the window still holds tail pixels of the previous row.
- Back-to-back frames: in_valid may stay high across the frame boundary. The pixel arriving in the cycle after the last pixel of a frame is accepted in IDLE as (0,0) of the next frame. There is no bubble, and frame_done and the new frame's start coexist without conflict.
- in_valid=0 in IDLE: idle, outputs low apart from held out_window/out_row/out_col.
- No arithmetic beyond counter increments; the data path is pass-through only.

Test Plan:
- Reset: assert rst mid-cycle with random inputs -> all outputs 0 immediately (asynchronously); release with in_valid=0 -> outputs stay 0.
- Full frame, 144 contiguous pixels, in_data=row*16+col, row1_data=(row-1)*16+col, row2_data=(row-2)*16+col:
  - first out_valid arrives 1 cycle after accepting pixel (2,2), i.e. cycle 27 after the first accept.
  - out_window(0,0)=0x00, (1,1)=0x11, (2,2)=0x22.
  - exactly 100 windows; frame_done occurs once, with out_row=9, out_col=9, window(2,2)=0xBB.
- Row wrap: during the same frame, no out_valid after accepting any pixel with col 0 or 1; out_col sequence per row is 0..9.
- Stream break: drop in_valid for 1 cycle at pixel (5,4) -> stream_err pulses once; no further out_valid. A new 144-pixel frame then yields 100 windows, the first at out_row=0, out_col=0.
- Back-to-back: two frames with in_valid held high for 288 cycles -> 200 windows, 2 frame_done pulses 144 cycles apart, stream_err never asserted.
- Mid-frame reset: assert rst at pixel (7,3), then run a clean frame -> no stale out_valid, and 100 windows with the first at out_row=0, out_col=0.

Source files
------------

// File: rtl/conv3x3_window_gen_if.sv
// Stream/window bundle between the row delay FIFOs, the 3x3 window generator and the MAC array.
interface conv3x3_window_gen_if #(
  parameter int DATA_W = 128,
  parameter int ROW_W  = 12,
  parameter int ROW_H  = 12
);
  localparam int RW = $clog2(ROW_H);
  localparam int CW = $clog2(ROW_W);

  logic                  in_valid;
  logic [DATA_W-1:0]     in_data;
  logic [DATA_W-1:0]     row1_data;
  logic [DATA_W-1:0]     row2_data;
  logic                  out_valid;
  logic [9*DATA_W-1:0]   out_window;
  logic [RW-1:0]         out_row;
  logic [CW-1:0]         out_col;
  logic                  frame_done;
  logic                  stream_err;

  modport master (
    output in_valid, in_data, row1_data, row2_data,
    input  out_valid, out_window, out_row, out_col, frame_done, stream_err
  );

  modport slave (
    input  in_valid, in_data, row1_data, row2_data,
    output out_valid, out_window, out_row, out_col, frame_done, stream_err
  );
endinterface

// File: rtl/conv3x3_window_gen.sv
// Sliding 3x3 window over three vertically aligned row streams; emits one window per
// legal (unpadded) convolution position with row/col tags, frame_done and stream_err pulses.
module conv3x3_window_gen #(
  parameter int DATA_W = 128,
  parameter int ROW_W  = 12,
  parameter int ROW_H  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  conv3x3_window_gen_if.slave  bus
);
  localparam int RW = $clog2(ROW_H);
  localparam int CW = $clog2(ROW_W);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(ROW_W - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]                   state_q, state_d;
  logic [RW-1:0]                row_q, row_d, orow_q, orow_d;
  logic [CW-1:0]                col_q, col_d, ocol_q, ocol_d;
  logic [2:0][2:0][DATA_W-1:0]  win_q, win_d;
  logic                         vld_q, vld_d, done_q, done_d, err_q, err_d;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    win_d   = win_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = bus.row2_data;
      win_d[1][2] = bus.row1_data;
      win_d[2][2] = bus.in_data;
      // The window is complete once two rows and two columns of history exist.
      vld_d = (row_q >= RW'(2)) && (col_q >= CW'(2));
      if (vld_d) begin
        orow_d = row_q - RW'(2);
        ocol_d = col_q - CW'(2);
      end
      done_d = vld_d && (row_q == ROW_LAST) && (col_q == COL_LAST);
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d   = '0;
          state_d = IDLE;
        end else begin
          row_d   = row_q + RW'(1);
          state_d = RUN;
        end
      end else begin
        col_d   = col_q + CW'(1);
        state_d = RUN;
      end
    end else if (state_q == RUN) begin
      // Delay FIFOs have already shifted out of alignment; abandon the frame.
      state_d = IDLE;
      row_d   = '0;
      col_d   = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      win_q   <= '0;
      orow_q  <= '0;
      ocol_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      win_q   <= win_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.out_valid  = vld_q;
  assign bus.out_window = win_q;
  assign bus.out_row    = orow_q;
  assign bus.out_col    = ocol_q;
  assign bus.frame_done = done_q;
  assign bus.stream_err = err_q;
endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Directed bench for conv3x3_window_gen: checkpoint table over a full frame plus
// stream-break, back-to-back and mid-frame reset sequences.
module tb_conv3x3_window_gen;
  localparam int DW = 128;
  localparam int W  = 12;
  localparam int H  = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv3x3_window_gen_if #(.DATA_W(DW), .ROW_W(W), .ROW_H(H)) bus ();
  conv3x3_window_gen #(.DATA_W(DW), .ROW_W(W), .ROW_H(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int k;      // pixel index within frame (row*W+col) accepted at the edge
    bit vld;
    int orow;
    int ocol;
    int e00;
    int e22;
    bit done;
  } vec_t;

  vec_t tbl[10];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nwin, ndone, first_r, first_c;
  int done_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic clr_stats();
    nwin = 0; ndone = 0; first_r = -1; first_c = -1;
    done_cyc.delete();
  endtask

  task automatic drive_pix(input int r, input int c);
    bus.in_valid  = 1'b1;
    bus.in_data   = DW'(r * 16 + c);
    bus.row1_data = DW'((r - 1) * 16 + c);
    bus.row2_data = DW'((r - 2) * 16 + c);
  endtask

  task automatic idle_step();
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drives pixels 0..npix-1 of a frame contiguously and checks outputs after every edge.
  task automatic run_frame(input int npix, input bit use_tbl);
    for (int k = 0; k < npix; k++) begin
      int r, c;
      bit ev;
      logic [DW-1:0] el;
      r = k / W;
      c = k % W;
      drive_pix(r, c);
      @(posedge clk); #1;
      ev = (r >= 2) && (c >= 2);
      chk("out_valid", DW'(bus.out_valid), DW'(ev));
      chk("stream_err", DW'(bus.stream_err), '0);
      chk("frame_done", DW'(bus.frame_done), DW'(r == H - 1 && c == W - 1));
      if (ev) begin
        chk("out_row", DW'(bus.out_row), DW'(r - 2));
        chk("out_col", DW'(bus.out_col), DW'(c - 2));
        for (int i = 0; i < 9; i++) begin
          el = bus.out_window[i*DW +: DW];
          chk("window", el, DW'((r - 2 + i / 3) * 16 + (c - 2 + i % 3)));
        end
      end
      if (bus.out_valid) begin
        if (nwin == 0) begin first_r = bus.out_row; first_c = bus.out_col; end
        nwin++;
      end
      if (bus.frame_done) begin ndone++; done_cyc.push_back(cyc); end
      if (use_tbl) begin
        foreach (tbl[j]) if (tbl[j].k == k) begin
          chk($sformatf("tbl%0d.valid", j), DW'(bus.out_valid), DW'(tbl[j].vld));
          if (tbl[j].vld) begin
            chk($sformatf("tbl%0d.row", j), DW'(bus.out_row), DW'(tbl[j].orow));
            chk($sformatf("tbl%0d.col", j), DW'(bus.out_col), DW'(tbl[j].ocol));
            el = bus.out_window[0 +: DW];
            chk($sformatf("tbl%0d.e00", j), el, DW'(tbl[j].e00));
            el = bus.out_window[8*DW +: DW];
            chk($sformatf("tbl%0d.e22", j), el, DW'(tbl[j].e22));
            chk($sformatf("tbl%0d.done", j), DW'(bus.frame_done), DW'(tbl[j].done));
          end
        end
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".out_valid"}, DW'(bus.out_valid), '0);
    chk({tag, ".frame_done"}, DW'(bus.frame_done), '0);
    chk({tag, ".stream_err"}, DW'(bus.stream_err), '0);
    chk({tag, ".out_row"}, DW'(bus.out_row), '0);
    chk({tag, ".out_col"}, DW'(bus.out_col), '0);
    chk({tag, ".window_nz"}, DW'(|bus.out_window), '0);
  endtask

  initial begin
    tbl[0] = '{k:0,   vld:0, orow:0, ocol:0, e00:'h00, e22:'h00, done:0};
    tbl[1] = '{k:24,  vld:0, orow:0, ocol:0, e00:'h00, e22:'h00, done:0};
    tbl[2] = '{k:25,  vld:0, orow:0, ocol:0, e00:'h00, e22:'h00, done:0};
    tbl[3] = '{k:26,  vld:1, orow:0, ocol:0, e00:'h00, e22:'h22, done:0};
    tbl[4] = '{k:27,  vld:1, orow:0, ocol:1, e00:'h01, e22:'h23, done:0};
    tbl[5] = '{k:35,  vld:1, orow:0, ocol:9, e00:'h09, e22:'h2B, done:0};
    tbl[6] = '{k:36,  vld:0, orow:0, ocol:0, e00:'h00, e22:'h00, done:0};
    tbl[7] = '{k:38,  vld:1, orow:1, ocol:0, e00:'h10, e22:'h32, done:0};
    tbl[8] = '{k:142, vld:1, orow:9, ocol:8, e00:'h98, e22:'hBA, done:0};
    tbl[9] = '{k:143, vld:1, orow:9, ocol:9, e00:'h99, e22:'hBB, done:1};

    bus.in_valid = 1'b0; bus.in_data = '0; bus.row1_data = '0; bus.row2_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_all_zero("reset");
    idle_step();
    chk_all_zero("idle_after_reset");

    // Full frame with checkpoint table; first window lands 27 cycles after the first accept.
    clr_stats();
    run_frame(W * H, 1'b1);
    chk("frame1.windows", DW'(nwin), DW'(100));
    chk("frame1.done_cnt", DW'(ndone), DW'(1));
    chk("frame1.first_row", DW'(first_r), '0);
    chk("frame1.first_col", DW'(first_c), '0);
    idle_step();
    chk("idle.out_valid", DW'(bus.out_valid), '0);
    chk("idle.frame_done", DW'(bus.frame_done), '0);
    chk("idle.stream_err", DW'(bus.stream_err), '0);

    // Stream break: pixels up to (5,3) accepted, in_valid low where (5,4) was due.
    clr_stats();
    run_frame(5 * W + 4, 1'b0);
    idle_step();
    chk("break.stream_err", DW'(bus.stream_err), DW'(1));
    chk("break.out_valid", DW'(bus.out_valid), '0);
    for (int i = 0; i < 4; i++) begin
      idle_step();
      chk("break.err_pulse", DW'(bus.stream_err), '0);
      chk("break.no_valid", DW'(bus.out_valid), '0);
    end
    clr_stats();
    run_frame(W * H, 1'b1);
    chk("after_break.windows", DW'(nwin), DW'(100));
    chk("after_break.first_row", DW'(first_r), '0);
    chk("after_break.first_col", DW'(first_c), '0);
    idle_step();

    // Back-to-back frames with in_valid held high throughout.
    clr_stats();
    run_frame(W * H, 1'b0);
    run_frame(W * H, 1'b1);
    chk("b2b.windows", DW'(nwin), DW'(200));
    chk("b2b.done_cnt", DW'(ndone), DW'(2));
    if (done_cyc.size() == 2)
      chk("b2b.done_gap", DW'(done_cyc[1] - done_cyc[0]), DW'(144));
    idle_step();
    chk("b2b.stream_err", DW'(bus.stream_err), '0);

    // Mid-frame asynchronous reset while presenting pixel (7,3).
    clr_stats();
    run_frame(7 * W + 3, 1'b0);
    drive_pix(7, 3);
    bus.in_data = DW'($urandom); bus.row1_data = DW'($urandom);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_reset");
    @(posedge clk); #1;
    chk_all_zero("reset_held");
    bus.in_valid = 1'b0;
    rst = 1'b0;
    idle_step();
    chk_all_zero("reset_release");
    clr_stats();
    run_frame(W * H, 1'b1);
    chk("post_reset.windows", DW'(nwin), DW'(100));
    chk("post_reset.first_row", DW'(first_r), '0);
    chk("post_reset.first_col", DW'(first_c), '0);
    idle_step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
